// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int CNT_W      = $clog2(OVERSAMPLE);

  localparam logic [CNT_W-1:0] MID_SAMPLE  = CNT_W'(7);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(15);

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, reset to RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_p0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_p0 <= RST_VAL;
      o_q     <= RST_VAL;
    end else begin
      meta_p0 <= i_d;
      o_q     <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with valid/ready holding register and
// framing, parity and overrun status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             PODD     = (PARITY_ODD != 0);

  uart_rx_state_e       state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 armed, armed_n;
  logic                 perr, perr_n;
  logic                 done, ferr;
  logic                 rx_s;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    armed_n = armed;
    perr_n  = perr;
    done    = 1'b0;
    ferr    = 1'b0;
    if (i_stick) begin
      case (state)
        IDLE: begin
          if (rx_s) begin
            armed_n = 1'b1;
          end else if (armed) begin
            state_n = START;
            cnt_n   = '0;
            perr_n  = 1'b0;
          end
        end
        START: begin
          cnt_n = cnt + 1'b1;
          if (cnt == MID_SAMPLE) begin
            // A start bit that is gone by mid-bit was noise, not a frame
            if (!rx_s) begin
              state_n = DATA;
              cnt_n   = '0;
              idx_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        DATA: begin
          cnt_n = cnt + 1'b1;
          if (cnt == LAST_SAMPLE) begin
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            cnt_n   = '0;
            idx_n   = idx + 1'b1;
            if (idx == IDX_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          cnt_n = cnt + 1'b1;
          if (cnt == LAST_SAMPLE) begin
            perr_n  = (^shreg) ^ rx_s ^ PODD;
            cnt_n   = '0;
            state_n = STOP;
          end
        end
        STOP: begin
          cnt_n = cnt + 1'b1;
          if (cnt == LAST_SAMPLE) begin
            // Disarm on a bad stop so a held-low break yields one word only
            done    = 1'b1;
            ferr    = ~rx_s;
            armed_n = rx_s;
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      armed <= 1'b1;
      perr  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      armed <= armed_n;
      perr  <= perr_n;
    end
  end

  always_ff @(posedge i_clk) begin
    shreg <= shreg_n;
  end

  // Holding register: a completion may reload in the same cycle the old word is taken
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (done) begin
        if (!o_valid || i_ready) begin
          o_data       <= shreg;
          o_frame_err  <= ferr;
          o_parity_err <= perr;
          o_valid      <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 instance and an 8E1 instance on separate lines.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stick;
  logic       rx, rx_p;
  logic       rdy, rdy_p;
  logic [7:0] data, data_p;
  logic       vld, vld_p;
  logic       ferr, ferr_p;
  logic       perr, perr_p;
  logic       ovr, ovr_p;
  logic       busy, busy_p;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int rise_cnt = 0;
  int ovr_cnt = 0;
  logic vld_q = 1'b0;
  logic vb, va;
  int rise0, ovr0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    stick = 1'b0;
    forever begin
      @(negedge clk);
      stick = (cyc % 4 == 3);
    end
  end

  always @(posedge clk) begin
    #1;
    if (vld && !vld_q) rise_cnt++;
    vld_q = vld;
    if (ovr) ovr_cnt++;
  end

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stick      (stick),
    .i_rx         (rx),
    .o_data       (data),
    .o_valid      (vld),
    .i_ready      (rdy),
    .o_frame_err  (ferr),
    .o_parity_err (perr),
    .o_overrun    (ovr),
    .o_busy       (busy)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stick      (stick),
    .i_rx         (rx_p),
    .o_data       (data_p),
    .o_valid      (vld_p),
    .i_ready      (rdy_p),
    .o_frame_err  (ferr_p),
    .o_parity_err (perr_p),
    .o_overrun    (ovr_p),
    .o_busy       (busy_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit p, input logic v);
    if (p) rx_p = v;
    else rx = v;
  endtask

  task automatic align();
    while (cyc % 4 != 0) @(negedge clk);
  endtask

  // Stop-bit sample lands 36 clocks into the stop bit with this alignment
  task automatic send_frame(input bit p, input logic [7:0] d, input bit has_par,
                            input bit par, input bit stop, input bit rdy_at_done);
    align();
    drive(p, 1'b0);
    wait_clk(64);
    for (int i = 0; i < 8; i++) begin
      drive(p, d[i]);
      wait_clk(64);
    end
    if (has_par) begin
      drive(p, par);
      wait_clk(64);
    end
    drive(p, stop);
    wait_clk(35);
    vb = p ? vld_p : vld;
    if (rdy_at_done) begin
      if (p) rdy_p = 1'b1;
      else rdy = 1'b1;
    end
    wait_clk(1);
    va = p ? vld_p : vld;
    if (rdy_at_done) begin
      rdy   = 1'b0;
      rdy_p = 1'b0;
    end
    wait_clk(28);
    drive(p, 1'b1);
  endtask

  task automatic accept(input bit p, input string tag);
    if (p) rdy_p = 1'b1;
    else rdy = 1'b1;
    wait_clk(1);
    check(tag, p ? vld_p : vld, 1'b0);
    rdy   = 1'b0;
    rdy_p = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    rx_p  = 1'b1;
    rdy   = 1'b0;
    rdy_p = 1'b0;
    wait_clk(4);
    check("rst_valid", vld, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_ferr", ferr, 1'b0);
    check("rst_perr", perr, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_clk(70);

    // 8N1 0xA5 with exact output latency
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_valid_before", vb, 1'b0);
    check("a5_valid_after", va, 1'b1);
    check("a5_data", data, 8'hA5);
    check("a5_ferr", ferr, 1'b0);
    check("a5_perr", perr, 1'b0);
    check("a5_held", vld, 1'b1);
    accept(1'b0, "a5_accept");

    // Glitch on the start bit
    rise0 = rise_cnt;
    align();
    rx = 1'b0;
    wait_clk(10);
    check("glitch_busy", busy, 1'b1);
    wait_clk(10);
    rx = 1'b1;
    wait_clk(640);
    check("glitch_idle", busy, 1'b0);
    check("glitch_valid", vld, 1'b0);
    check("glitch_rise", rise_cnt - rise0, 0);
    check("glitch_ferr", ferr, 1'b0);

    // Framing error then break
    rise0 = rise_cnt;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    check("brk_valid", va, 1'b1);
    check("brk_data", data, 8'h3C);
    check("brk_ferr", ferr, 1'b1);
    wait_clk(640);
    accept(1'b0, "brk_accept");
    wait_clk(1279);
    check("brk_busy", busy, 1'b0);
    check("brk_valid_after", vld, 1'b0);
    check("brk_one_word", rise_cnt - rise0, 1);
    rx = 1'b1;
    wait_clk(64);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_brk_data", data, 8'h81);
    check("post_brk_ferr", ferr, 1'b0);
    check("post_brk_valid", vld, 1'b1);
    accept(1'b0, "post_brk_accept");

    // Parity, even
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    check("par_bad_valid_before", vb, 1'b0);
    check("par_bad_valid", va, 1'b1);
    check("par_bad_data", data_p, 8'h07);
    check("par_bad_perr", perr_p, 1'b1);
    check("par_bad_ferr", ferr_p, 1'b0);
    accept(1'b1, "par_bad_accept");
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    check("par_ok_valid", va, 1'b1);
    check("par_ok_perr", perr_p, 1'b0);
    accept(1'b1, "par_ok_accept");

    // Overrun with the consumer stalled
    ovr0 = ovr_cnt;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_pulse", ovr_cnt - ovr0, 1);
    check("ovr_data", data, 8'h11);
    check("ovr_valid", vld, 1'b1);
    accept(1'b0, "ovr_accept");

    // Accept in the same cycle as the next completion
    ovr0 = ovr_cnt;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    check("reload_valid", va, 1'b1);
    check("reload_data", data, 8'h22);
    check("reload_no_ovr", ovr_cnt - ovr0, 0);
    accept(1'b0, "reload_accept");

    // Reset mid-frame after data bit 3
    align();
    rx = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h5A >> i) & 8'h01;
      wait_clk(64);
    end
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    wait_clk(1);
    check("mid_rst_valid", vld, 1'b0);
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_ferr", ferr, 1'b0);
    check("mid_rst_perr", perr, 1'b0);
    check("mid_rst_ovr", ovr, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    wait_clk(4);
    rx = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(128);
    check("post_rst_valid0", vld, 1'b0);
    rise0 = rise_cnt;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_valid", va, 1'b1);
    check("post_rst_data", data, 8'h5A);
    check("post_rst_ferr", ferr, 1'b0);
    accept(1'b0, "post_rst_accept");
    wait_clk(640);
    check("post_rst_single", rise_cnt - rise0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
